gpio_debounce: RTL and testbench

Per-pin input conditioning stage that sits directly upstream of the GPIO block, between the pad inputs and the GPIO r_data input.
- Synchronizes each asynchronous pad input.
- Rejects glitches shorter than a programmable number of clock cycles.
- Presents a clean, stable level per pin, plus single-cycle rise/fall/change strobes for optional downstream use.

---
 rtl/gpio_pkg.sv | 16 +
 rtl/gpio_debounce_cell.sv | 78 +++++++
 rtl/gpio_debounce.sv | 56 +++++
 tb/tb_gpio_debounce.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// ============================================================================
// Module      : gpio_pkg
// Description : Shared constants and types for the GPIO input path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpio_pkg;
  localparam int GPIO_MAX_PINS = 32;
  localparam int DEBOUNCE_CNT_W = 8;
  localparam logic [DEBOUNCE_CNT_W-1:0] DEFAULT_DEBOUNCE_THR = 8'd4;

  typedef logic [DEBOUNCE_CNT_W-1:0] debounce_cnt_t;
endpackage

`default_nettype wire

// File: rtl/gpio_debounce_cell.sv
// ============================================================================
// Module      : gpio_debounce_cell
// Description : Single-pin glitch filter with registered rise/fall/change strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_debounce_cell
  import gpio_pkg::*;
#(
  parameter int CNT_WIDTH = DEBOUNCE_CNT_W
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 sync_bit,
  input  logic [CNT_WIDTH-1:0] threshold,
  input  logic                 bypass,
  output logic                 filt,
  output logic                 rise,
  output logic                 fall,
  output logic                 change
);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_filt;
  logic                 r_rise;
  logic                 r_fall;
  logic                 r_change;

  logic [CNT_WIDTH-1:0] w_thr_eff;
  logic [CNT_WIDTH:0]   w_cnt_inc;
  logic                 w_filt_next;
  logic [CNT_WIDTH-1:0] w_cnt_next;

  assign w_thr_eff = (threshold == '0) ? CNT_WIDTH'(1) : threshold;
  // One bit wider so the count+1 compare can never wrap.
  assign w_cnt_inc = {1'b0, r_cnt} + (CNT_WIDTH+1)'(1);

  always_comb begin
    w_filt_next = r_filt;
    w_cnt_next  = r_cnt;
    if (bypass) begin
      w_filt_next = sync_bit;
      w_cnt_next  = '0;
    end else if (sync_bit == r_filt) begin
      w_cnt_next  = '0;
    end else if (w_cnt_inc >= {1'b0, w_thr_eff}) begin
      w_filt_next = sync_bit;
      w_cnt_next  = '0;
    end else begin
      w_cnt_next  = w_cnt_inc[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt    <= '0;
      r_filt   <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_change <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_next;
      r_filt   <= w_filt_next;
      r_rise   <= w_filt_next & ~r_filt;
      r_fall   <= ~w_filt_next & r_filt;
      r_change <= w_filt_next ^ r_filt;
    end
  end

  assign filt   = r_filt;
  assign rise   = r_rise;
  assign fall   = r_fall;
  assign change = r_change;

endmodule

`default_nettype wire

// File: rtl/gpio_debounce.sv
// ============================================================================
// Module      : gpio_debounce
// Description : Two-flop pad synchronizer feeding one debounce cell per pin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int NUM_PINS  = 8,
  parameter int CNT_WIDTH = DEBOUNCE_CNT_W
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [NUM_PINS-1:0]  pad_in,
  input  logic [CNT_WIDTH-1:0] threshold,
  input  logic [NUM_PINS-1:0]  bypass,
  output logic [NUM_PINS-1:0]  filt_out,
  output logic [NUM_PINS-1:0]  rise_pulse,
  output logic [NUM_PINS-1:0]  fall_pulse,
  output logic [NUM_PINS-1:0]  change_pulse
);

  logic [NUM_PINS-1:0] r_sync_in;
  logic [NUM_PINS-1:0] r_sync_out;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sync_in  <= '0;
      r_sync_out <= '0;
    end else begin
      r_sync_in  <= pad_in;
      r_sync_out <= r_sync_in;
    end
  end

  for (genvar gi = 0; gi < NUM_PINS; gi++) begin : g_pin
    gpio_debounce_cell #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_cell (
      .clk       (clk),
      .n_rst     (n_rst),
      .sync_bit  (r_sync_out[gi]),
      .threshold (threshold),
      .bypass    (bypass[gi]),
      .filt      (filt_out[gi]),
      .rise      (rise_pulse[gi]),
      .fall      (fall_pulse[gi]),
      .change    (change_pulse[gi])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_gpio_debounce.sv
// ============================================================================
// Module      : tb_gpio_debounce
// Description : Directed self-checking bench for gpio_debounce.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpio_debounce;

  logic       clk;
  logic       n_rst;
  logic [7:0] pad_in;
  logic [7:0] threshold;
  logic [7:0] bypass;
  logic [7:0] filt_out;
  logic [7:0] rise_pulse;
  logic [7:0] fall_pulse;
  logic [7:0] change_pulse;

  int n_tests;
  int n_fail;

  gpio_debounce #(
    .NUM_PINS  (8),
    .CNT_WIDTH (8)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .pad_in       (pad_in),
    .threshold    (threshold),
    .bypass       (bypass),
    .filt_out     (filt_out),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .change_pulse (change_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges and settle 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic d0, d1, d2, d3;

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    n_rst     = 1'b0;
    pad_in    = 8'h00;
    threshold = 8'd3;
    bypass    = 8'h00;

    // Reset state
    step(2);
    check("rst_filt",   32'(filt_out),     32'h0);
    check("rst_rise",   32'(rise_pulse),   32'h0);
    check("rst_fall",   32'(fall_pulse),   32'h0);
    check("rst_change", 32'(change_pulse), 32'h0);
    n_rst = 1'b1;
    step(3);

    // Pin 0, threshold 3: filt at E+4
    pad_in[0] = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      step(1);
      check("t1_filt_low", 32'(filt_out[0]), 32'h0);
    end
    step(1);
    check("t1_filt_high", 32'(filt_out[0]),     32'h1);
    check("t1_rise",      32'(rise_pulse[0]),   32'h1);
    check("t1_change",    32'(change_pulse[0]), 32'h1);
    step(1);
    check("t1_rise_once", 32'(rise_pulse[0]),   32'h0);
    check("t1_filt_hold", 32'(filt_out[0]),     32'h1);

    // Pin 1: 2-cycle glitch with threshold 3 is rejected
    pad_in[1] = 1'b1;
    step(2);
    pad_in[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(1);
      check("t2_filt",   32'(filt_out[1]),  32'h0);
      check("t2_rise",   32'(rise_pulse),   32'h0);
      check("t2_fall",   32'(fall_pulse),   32'h0);
      check("t2_change", 32'(change_pulse), 32'h0);
    end

    // Pin 2, threshold 0 behaves as 1: filt at E+2
    threshold = 8'd0;
    pad_in[2] = 1'b1;
    step(1);
    check("t3_filt_e0", 32'(filt_out[2]), 32'h0);
    step(1);
    check("t3_filt_e1", 32'(filt_out[2]), 32'h0);
    step(1);
    check("t3_filt_e2", 32'(filt_out[2]),   32'h1);
    check("t3_rise",    32'(rise_pulse[2]), 32'h1);

    // Pin 3 bypassed with a huge threshold: follows pad with 2-edge delay
    threshold = 8'd200;
    bypass    = 8'h08;
    d0 = 1'b0; d1 = 1'b0; d2 = 1'b0; d3 = 1'b0;
    for (int k = 0; k < 18; k++) begin
      if ((k % 3) == 0) pad_in[3] = ~pad_in[3];
      step(1);
      d3 = d2; d2 = d1; d1 = d0; d0 = pad_in[3];
      check("t4_filt", 32'(filt_out[3]),   32'(d2));
      check("t4_rise", 32'(rise_pulse[3]), 32'(d2 & ~d3));
      check("t4_fall", 32'(fall_pulse[3]), 32'(~d2 & d3));
    end

    // Pin 4: lowering threshold mid-count accepts on the next edge
    threshold = 8'd10;
    pad_in[4] = 1'b1;
    step(1);
    step(6);
    check("t5_filt_wait", 32'(filt_out[4]), 32'h0);
    threshold = 8'd4;
    step(1);
    check("t5_filt_high", 32'(filt_out[4]),   32'h1);
    check("t5_rise",      32'(rise_pulse[4]), 32'h1);

    // Pin 5: reset mid-count discards the count; rise 12 edges after release
    threshold = 8'd10;
    pad_in[5] = 1'b1;
    step(5);
    n_rst = 1'b0;
    #1;
    check("t6_rst_filt",   32'(filt_out),     32'h0);
    check("t6_rst_rise",   32'(rise_pulse),   32'h0);
    check("t6_rst_fall",   32'(fall_pulse),   32'h0);
    check("t6_rst_change", 32'(change_pulse), 32'h0);
    step(2);
    check("t6_rst_hold", 32'(filt_out), 32'h0);
    n_rst = 1'b1;
    step(11);
    check("t6_filt_e11", 32'(filt_out[5]), 32'h0);
    step(1);
    check("t6_filt_e12", 32'(filt_out[5]),   32'h1);
    check("t6_rise_e12", 32'(rise_pulse[5]), 32'h1);
    step(1);
    check("t6_rise_once", 32'(rise_pulse[5]), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
